// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 codes, FSM states,
// latched request layout and the request legality check.
package rv_mem_pkg;

  localparam int TIMEOUT_DEF = 64;
  localparam int NUM_LANES   = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [15:0] sdata;
  } mem_req_t;

  // Unsigned widths exist only for loads; a store with 100/101 is illegal.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = rd & wr;
    case (f3)
      F3_LB:   bad = bad;
      F3_LH:   bad = bad | lo[0];
      F3_LW:   bad = bad | (|lo);
      F3_LBU:  bad = bad | wr;
      F3_LHU:  bad = bad | wr | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge into a
// previously read word.
module load_store_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [15:0] sdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [NUM_LANES-1:0][7:0] wr_lanes;
  logic [NUM_LANES-1:0]      be;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;

  assign rd_lanes = rdata;
  assign byte_sel = rd_lanes[lane];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_ext = rdata;
    case (func3)
      F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_ext = {24'h0, byte_sel};
      F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_ext = {16'h0, half_sel};
      default: load_ext = rdata;
    endcase
  end

  // funct3[0] distinguishes SH from SB; SW never goes through the merge.
  assign be = func3[0] ? (lane[1] ? 4'b1100 : 4'b0011) : (4'b0001 << lane);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_lanes[i] = be[i] ? (func3[0] ? sdata[(i%2)*8 +: 8] : sdata[7:0])
                               : rd_lanes[i];
  end

  assign merged = wr_lanes;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: one load/store per instruction over the
// mem_read/mem_write/busywait handshake, with RMW for SB/SH and fault pulses.
module mem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_func3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_fault,
  output logic        timeout_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        busywait
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  mem_req_t      req_q;
  logic [31:0]   wdata_q;
  logic [31:0]   load_q;
  logic          to_q;

  logic          req, bad, in_req, done_req, expired;
  logic [31:0]   ext, merged;

  assign req      = ex_mem_read | ex_mem_write;
  assign bad      = req_illegal(ex_mem_read, ex_mem_write, ex_func3, ex_addr[1:0]);
  assign in_req   = state_q inside {ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR};
  // cnt_q is 0 during the first request cycle, so any completing edge is eligible.
  assign done_req = in_req & ~busywait;
  assign expired  = in_req & busywait & (cnt_q == CW'(TIMEOUT - 1));

  load_store_align u_align (
    .func3    (req_q.func3),
    .lane     (req_q.addr[1:0]),
    .rdata    (mem_rdata),
    .sdata    (req_q.sdata),
    .load_ext (ext),
    .merged   (merged)
  );

  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    load_valid     = 1'b0;
    misalign_fault = 1'b0;
    timeout_fault  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (bad)                    state_d = ST_FAULT;
          else if (ex_mem_read)       state_d = ST_RD;
          else if (ex_func3 == F3_LW) state_d = ST_WR;
          else                        state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        if (done_req)     state_d = ST_DONE;
        else if (expired) state_d = ST_FAULT;
      end
      ST_RMW_RD: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        if (done_req)     state_d = ST_RMW_WR;
        else if (expired) state_d = ST_FAULT;
      end
      ST_WR, ST_RMW_WR: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        if (done_req)     state_d = ST_DONE;
        else if (expired) state_d = ST_FAULT;
      end
      ST_DONE: begin
        load_valid = req_q.is_load;
        state_d    = ST_IDLE;
      end
      ST_FAULT: begin
        misalign_fault = ~to_q;
        timeout_fault  = to_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (in_req)        cnt_q <= cnt_q + CW'(1);
      if (state_q == ST_IDLE && req) begin
        req_q   <= '{is_load: ex_mem_read & ~ex_mem_write, func3: ex_func3,
                     addr: ex_addr, sdata: ex_store_data[15:0]};
        wdata_q <= ex_store_data;
        to_q    <= 1'b0;
      end
      if (expired) to_q <= 1'b1;
      if (state_q == ST_RD && done_req)     load_q  <= ext;
      if (state_q == ST_RMW_RD && done_req) wdata_q <= merged;
    end
  end

  assign mem_address = {2'b00, req_q.addr[31:2]};
  assign mem_wdata   = wdata_q;
  assign load_data   = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a latency-controlled memory model
// and a scoreboard of per-instruction expectations.
module tb_mem_access_unit;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [2:0]  ex_func3 = 3'b0;
  logic [31:0] ex_addr = '0, ex_store_data = '0;
  logic        stall, load_valid, misalign_fault, timeout_fault, mem_read, mem_write;
  logic [31:0] load_data, mem_address, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busywait = 1'b0;

  mem_access_unit #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_func3(ex_func3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misalign_fault(misalign_fault), .timeout_fault(timeout_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busywait(busywait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv, mf, tf;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0, bad = 0;
  logic [31:0] mem [256];
  int          lat = 0, kcnt = 0, nreq = 0, rd_cycles = 0;
  logic [1:0]  prev = 2'b00;
  logic        both_seen = 1'b0;
  logic [31:0] last_addr = '0, last_load = '0;

  // Memory: busywait stays high for `lat` cycles of each request, then the
  // access completes at the following posedge.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_seen = 1'b1;
    if (!mem_read && !mem_write) begin
      busywait = 1'b0;
      kcnt = 0;
    end else begin
      if ({mem_read, mem_write} != prev) begin
        kcnt = 0;
        nreq++;
        last_addr = mem_address;
      end
      busywait = (kcnt < lat);
      if (mem_read) begin
        rd_cycles++;
        mem_rdata = mem[mem_address[7:0]];
      end
      if (mem_write && !busywait) mem[mem_address[7:0]] = mem_wdata;
      kcnt++;
    end
    prev = {mem_read, mem_write};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input int l,
                        input logic mf, input logic tf, input logic [31:0] ldata,
                        input int stalls, input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    lat = l;
    e.lv = rd & ~wr & ~mf & ~tf;
    e.mf = mf;
    e.tf = tf;
    if (e.lv) last_load = ldata;
    e.data   = last_load;
    e.stalls = stalls;
    sb_q.push_back(e);
    ex_mem_read = rd; ex_mem_write = wr; ex_func3 = f3; ex_addr = addr; ex_store_data = data;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    e = sb_q.pop_front();
    chk({tag, " stalls"}, n, e.stalls);
    chk({tag, " load_valid"}, load_valid, e.lv);
    chk({tag, " misalign"}, misalign_fault, e.mf);
    chk({tag, " timeout"}, timeout_fault, e.tf);
    chk({tag, " load_data"}, load_data, e.data);
    ex_mem_read = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  initial begin
    int n0, n;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    mem[1] = 32'h1122_3344;
    mem[3] = 32'h0102_0304;
    mem[4] = 32'hDEAD_BEEF;
    #1 reset = 1'b0;
    #1;
    chk("reset ctl", {28'h0, stall, load_valid, misalign_fault, timeout_fault}, 32'h0);
    chk("reset req", {30'h0, mem_read, mem_write}, 32'h0);
    chk("reset addr", mem_address, 32'h0);
    chk("reset wdata", mem_wdata, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    access(1, 0, F3_LW, 32'h10, 0, 0, 0, 0, 32'hDEAD_BEEF, 2, "lw");
    chk("lw mem_address", last_addr, 32'h4);
    chk("lw rd cycles", rd_cycles, 1);

    mem[4] = 32'h80FF_7F01;
    access(1, 0, F3_LB,  32'h13, 0, 0, 0, 0, 32'hFFFF_FF80, 2, "lb 13");
    access(1, 0, F3_LBU, 32'h13, 0, 0, 0, 0, 32'h0000_0080, 2, "lbu 13");
    access(1, 0, F3_LH,  32'h12, 0, 0, 0, 0, 32'hFFFF_80FF, 2, "lh 12");
    access(1, 0, F3_LHU, 32'h10, 0, 0, 0, 0, 32'h0000_7F01, 2, "lhu 10");
    access(1, 0, F3_LB,  32'h11, 0, 0, 0, 0, 32'h0000_007F, 2, "lb 11");
    access(1, 0, F3_LW,  32'h10, 0, 3, 0, 0, 32'h80FF_7F01, 5, "lw slow");

    n0 = nreq;
    access(0, 1, F3_LB, 32'h05, 32'h1234_56AA, 0, 0, 0, 0, 3, "sb");
    chk("sb word", mem[1], 32'h1122_AA44);
    chk("sb requests", nreq - n0, 2);
    access(0, 1, F3_LH, 32'h06, 32'hFFFF_BEEF, 2, 0, 0, 0, 7, "sh slow");
    chk("sh word", mem[1], 32'hBEEF_AA44);
    access(0, 1, F3_LW, 32'h08, 32'hCAFE_F00D, 0, 0, 0, 0, 2, "sw");
    chk("sw word", mem[2], 32'hCAFE_F00D);
    access(1, 0, F3_LW, 32'h04, 0, 0, 0, 0, 32'hBEEF_AA44, 2, "lw back");

    n0 = nreq;
    access(1, 0, F3_LH,  32'h01, 0, 0, 1, 0, 0, 1, "lh mis");
    access(0, 1, F3_LW,  32'h02, 0, 0, 1, 0, 0, 1, "sw mis");
    access(1, 0, 3'b011, 32'h00, 0, 0, 1, 0, 0, 1, "f3 011");
    access(1, 1, F3_LW,  32'h00, 0, 0, 1, 0, 0, 1, "rd+wr");
    access(0, 1, F3_LBU, 32'h00, 0, 0, 1, 0, 0, 1, "store bu");
    chk("fault requests", nreq - n0, 0);
    chk("fault mem[0]", mem[0], 32'h0);

    n0 = rd_cycles;
    access(1, 0, F3_LW, 32'h10, 0, 100, 0, 1, 0, 65, "timeout");
    chk("timeout rd cycles", rd_cycles - n0, 64);
    chk("timeout idle req", {30'h0, mem_read, mem_write}, 32'h0);

    @(negedge clk);
    lat = 4;
    ex_mem_write = 1'b1; ex_func3 = F3_LB; ex_addr = 32'h0C; ex_store_data = 32'h55;
    n = 0;
    while (mem_write !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rmw_wr reached", {31'h0, mem_write}, 32'h1);
    #2;
    reset = 1'b0;
    ex_mem_write = 1'b0;
    #1;
    chk("rst req", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst ctl", {28'h0, stall, load_valid, misalign_fault, timeout_fault}, 32'h0);
    chk("rst addr", mem_address, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst load_data", load_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    chk("rst lost write", mem[3], 32'h0102_0304);
    last_load = 32'h0;
    access(1, 0, F3_LW, 32'h10, 0, 0, 0, 0, 32'h80FF_7F01, 2, "lw after rst");

    chk("rd&wr together", {31'h0, both_seen}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage initiator for the 256x32 word-addressed data memory. Takes one load/store per instruction from the EX/MEM register, drives the memory's mem_read/mem_write/busywait handshake, and stalls the pipeline until the access completes. Handles RV32 byte/half lanes: sign/zero extension on loads, read-modify-write for SB/SH. Flags misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT, 64: max cycles a request may stay outstanding before being abandoned.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; low forces reset state immediately.
- ex_mem_read  in  1  pipeline requests a load.
- ex_mem_write  in  1  pipeline requests a store.
- ex_func3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_addr  in  32  byte address.
- ex_store_data  in  32  store data, right-aligned.
- stall  out  1  freeze pipeline; the EX/MEM request is held stable while high.
- load_data  out  32  extended load result; valid only while load_valid=1.
- load_valid  out  1  one-cycle pulse, load complete.
- misalign_fault  out  1  one-cycle pulse: misaligned, illegal funct3, or read&write both high.
- timeout_fault  out  1  one-cycle pulse: TIMEOUT expired.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_address  out  32  word index = {2'b00, ex_addr[31:2]}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  word returned by memory.
- busywait  in  1  memory busy.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE, FAULT.
- IDLE: no request -> stay, stall=0. Request present -> stall=1 combinationally; latch addr, func3, data; classify:
  - both read and write, funct3 in {011,110,111} (or 100/101 on a store), H with addr[0]=1, W with addr[1:0]!=0 -> FAULT (no memory request ever issued).
  - load -> RD; SW -> WR; SB/SH -> RMW_RD.
- RD/WR/RMW_RD/RMW_WR: corresponding request line high, the other low. Completion = busywait sampled 0 at a posedge after the request has been high for at least one full cycle. On completion: RD captures mem_rdata -> DONE; RMW_RD captures word, merges new byte/half into lane addr[1:0]/addr[1] -> RMW_WR; WR/RMW_WR -> DONE. Request line drops on the completing edge.
- Timeout: cycle counter cleared on each request-state entry; reaching TIMEOUT -> drop request, go to FAULT with timeout_fault.
- DONE: stall=0; load_valid=1 for loads; -> IDLE. FAULT: stall=0, the relevant fault pulse=1 -> IDLE.
- Load extraction: B/BU byte lane addr[1:0], H/HU lane addr[1]; B/H sign-extend, BU/HU zero-extend; W passes through.
- mem_read and mem_write are never high together.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset asserted mid-access drops mem_read/mem_write asynchronously; the access is lost and no fault is reported.
- Minimum latency (memory completes on the first eligible edge): LW/SW = 2 stall cycles, then DONE; SB/SH = 3 stall cycles, then DONE; fault = 1 stall cycle, then FAULT.
- The pipeline advances at the end of DONE/FAULT; the next instruction is seen in IDLE on the following cycle (one-cycle bubble between back-to-back accesses).
- load_data is registered and held until the next load completes.
- busywait high at request entry does not cause completion; busywait must be sampled low after the first cycle of the request.

## Structure
- Package rv_mem_pkg: funct3 constants (F3_LB..F3_LHU), state enum, TIMEOUT default.
- Sub-module load_store_align: combinational lane extract/extend for loads and lane merge for stores; the FSM and counter live in mem_access_unit.

## Test plan
- LW at addr 0x10, memory word[4]=0xDEADBEEF, busywait low after 1 cycle -> mem_address=4, 2 stall cycles, load_valid with 0xDEADBEEF.
- LB/LBU at 0x13 on word 0x80FF7F01 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; LH at 0x12 gives 0xFFFF80FF.
- SB 0xAA at 0x05 on word[1]=0x11223344 -> RMW read then write of 0x1122AA44; 3 stall cycles; mem_read and mem_write never high together.
- LH at 0x01, SW at 0x02, funct3=011, and read&write both high -> misaligned fault pulse each, zero memory requests.
- busywait held high for 100 cycles with TIMEOUT=64 -> request dropped after 64 cycles, timeout_fault pulse, back to IDLE.
- reset low during RMW_WR -> mem_write goes 0 immediately, outputs all 0, the next LW completes normally.
